fight_arena: RTL and testbench

FIGHT_ARENA -- requirements
Module: fight_arena

---
 rtl/fight_pkg.sv | 37 +++
 rtl/fight_player_unit.sv | 73 +++++++
 rtl/fight_arena.sv | 100 ++++++++++
 tb/tb_fight_arena.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fight_pkg.sv
// Shared encodings for the fight arena: player actions, strike kinds,
// round FSM states and damage amounts.
package fight_pkg;

    typedef enum logic [2:0] {
        ACT_IDLE   = 3'b000,
        ACT_LEFT   = 3'b001,
        ACT_RIGHT  = 3'b010,
        ACT_ATTACK = 3'b011,
        ACT_DEFEND = 3'b100,
        ACT_HEAVY  = 3'b101
    } action_t;

    typedef enum logic [1:0] {
        STK_NONE  = 2'd0,
        STK_ATK   = 2'd1,
        STK_HEAVY = 2'd2
    } strike_t;

    typedef enum logic {
        ST_FIGHT = 1'b0,
        ST_OVER  = 1'b1
    } state_t;

    localparam logic [1:0] ATK_DMG           = 2'd1;
    localparam logic [1:0] HEAVY_DMG         = 2'd2;
    localparam logic [1:0] HEAVY_BLOCKED_DMG = 2'd1;

    function automatic logic [1:0] strike_dmg(input strike_t s, input logic defending);
        case (s)
            STK_ATK:   strike_dmg = defending ? 2'd0 : ATK_DMG;
            STK_HEAVY: strike_dmg = defending ? HEAVY_BLOCKED_DMG : HEAVY_DMG;
            default:   strike_dmg = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fight_player_unit.sv
// One player's state: health, attack cooldown, decoded move requests and
// intake of the opponent's strike.
module fight_player_unit
    import fight_pkg::*;
#(
    parameter int HEALTH_W   = 3,
    parameter int MAX_HEALTH = 7,
    parameter int COOLDOWN   = 2
) (
    input  logic                clk,
    input  logic                resetGame,
    input  logic                run_i,
    input  logic                act_en_i,
    input  logic [2:0]          action_i,
    input  strike_t             opp_strike_i,
    input  logic                adjacent_i,
    output strike_t             strike_o,
    output logic                mv_left_o,
    output logic                mv_right_o,
    output logic                busy_o,
    output logic [HEALTH_W-1:0] health_o,
    output logic [HEALTH_W-1:0] health_d_o
);

    localparam int CW = $clog2(COOLDOWN + 2);

    logic [CW-1:0]       cool_q, cool_d;
    logic [HEALTH_W-1:0] health_q;
    logic                defending;
    logic [1:0]          dmg;
    logic [HEALTH_W:0]   dmg_ext;

    always_comb begin
        strike_o   = STK_NONE;
        mv_left_o  = 1'b0;
        mv_right_o = 1'b0;
        defending  = 1'b0;
        if (act_en_i) begin
            case (action_i)
                ACT_LEFT:   mv_left_o  = 1'b1;
                ACT_RIGHT:  mv_right_o = 1'b1;
                ACT_DEFEND: defending  = 1'b1;
                // a strike while cooling down degrades to idle
                ACT_ATTACK: if (cool_q == '0) strike_o = STK_ATK;
                ACT_HEAVY:  if (cool_q == '0) strike_o = STK_HEAVY;
                default: ;
            endcase
        end

        dmg     = adjacent_i ? strike_dmg(opp_strike_i, defending) : 2'd0;
        dmg_ext = (HEALTH_W+1)'(dmg);
        if ({1'b0, health_q} <= dmg_ext) health_d_o = '0;
        else                             health_d_o = health_q - dmg_ext[HEALTH_W-1:0];

        cool_d = cool_q;
        if (strike_o != STK_NONE) cool_d = CW'(COOLDOWN);
        else if (cool_q != '0)    cool_d = cool_q - CW'(1);
    end

    always_ff @(posedge clk or negedge resetGame) begin
        if (!resetGame) begin
            cool_q   <= '0;
            health_q <= HEALTH_W'(MAX_HEALTH);
        end else if (run_i) begin
            cool_q   <= cool_d;
            health_q <= health_d_o;
        end
    end

    assign busy_o   = (cool_q != '0);
    assign health_o = health_q;

endmodule

// File: rtl/fight_arena.sv
// Two-player arena: move arbitration on a 1-D track, strike resolution via
// two player units, and the FIGHT/OVER round FSM with sticky result flags.
module fight_arena
    import fight_pkg::*;
#(
    parameter  int TRACK_LEN  = 8,
    parameter  int HEALTH_W   = 3,
    parameter  int MAX_HEALTH = 7,
    parameter  int COOLDOWN   = 2,
    localparam int PW         = $clog2(TRACK_LEN)
) (
    input  logic                clk,
    input  logic                resetGame,
    input  logic                action_valid,
    input  logic [2:0]          action1,
    input  logic [2:0]          action2,
    output logic [PW-1:0]       pos1,
    output logic [PW-1:0]       pos2,
    output logic [HEALTH_W-1:0] health1,
    output logic [HEALTH_W-1:0] health2,
    output logic                first_win,
    output logic                second_win,
    output logic                draw,
    output logic                busy1,
    output logic                busy2,
    output logic                round_over
);

    state_t              state_q;
    logic [PW-1:0]       pos1_q, pos2_q, pos1_d, pos2_d, gap;
    logic                first_q, second_q, draw_q, over_q;
    logic                fight, act_en, adjacent;
    strike_t             s1, s2;
    logic                m1l, m1r, m2l, m2r;
    logic [HEALTH_W-1:0] h1_d, h2_d;

    assign fight    = (state_q == ST_FIGHT);
    assign act_en   = fight && action_valid;
    assign gap      = pos2_q - pos1_q;
    assign adjacent = (gap == PW'(1));

    fight_player_unit #(.HEALTH_W(HEALTH_W), .MAX_HEALTH(MAX_HEALTH), .COOLDOWN(COOLDOWN)) u_p1 (
        .clk(clk), .resetGame(resetGame), .run_i(fight), .act_en_i(act_en),
        .action_i(action1), .opp_strike_i(s2), .adjacent_i(adjacent),
        .strike_o(s1), .mv_left_o(m1l), .mv_right_o(m1r), .busy_o(busy1),
        .health_o(health1), .health_d_o(h1_d)
    );

    fight_player_unit #(.HEALTH_W(HEALTH_W), .MAX_HEALTH(MAX_HEALTH), .COOLDOWN(COOLDOWN)) u_p2 (
        .clk(clk), .resetGame(resetGame), .run_i(fight), .act_en_i(act_en),
        .action_i(action2), .opp_strike_i(s1), .adjacent_i(adjacent),
        .strike_o(s2), .mv_left_o(m2l), .mv_right_o(m2r), .busy_o(busy2),
        .health_o(health2), .health_d_o(h2_d)
    );

    // Moves never target the opponent's current cell; converging at gap 2
    // would land both on the same cell, so both are cancelled.
    always_comb begin
        pos1_d = pos1_q;
        pos2_d = pos2_q;
        if (m1l && pos1_q != '0)
            pos1_d = pos1_q - PW'(1);
        if (m1r && gap != PW'(1) && !(m2l && gap == PW'(2)))
            pos1_d = pos1_q + PW'(1);
        if (m2r && pos2_q != PW'(TRACK_LEN-1))
            pos2_d = pos2_q + PW'(1);
        if (m2l && gap != PW'(1) && !(m1r && gap == PW'(2)))
            pos2_d = pos2_q - PW'(1);
    end

    always_ff @(posedge clk or negedge resetGame) begin
        if (!resetGame) begin
            state_q  <= ST_FIGHT;
            pos1_q   <= '0;
            pos2_q   <= PW'(TRACK_LEN-1);
            first_q  <= 1'b0;
            second_q <= 1'b0;
            draw_q   <= 1'b0;
            over_q   <= 1'b0;
        end else if (state_q == ST_FIGHT) begin
            pos1_q <= pos1_d;
            pos2_q <= pos2_d;
            if (h1_d == '0 || h2_d == '0) begin
                state_q  <= ST_OVER;
                over_q   <= 1'b1;
                draw_q   <= (h1_d == '0) && (h2_d == '0);
                first_q  <= (h1_d != '0);
                second_q <= (h2_d != '0);
            end
        end
    end

    assign pos1       = pos1_q;
    assign pos2       = pos2_q;
    assign first_win  = first_q;
    assign second_win = second_q;
    assign draw       = draw_q;
    assign round_over = over_q;

endmodule

// File: tb/tb_fight_arena.sv
// Directed bench for fight_arena with default parameters (8 cells, health 7,
// cooldown 2); expected values are hand-derived per step.
module tb_fight_arena;

    localparam logic [2:0] I = 3'b000, L = 3'b001, R = 3'b010, A = 3'b011,
                           D = 3'b100, H = 3'b101;

    logic       clk = 1'b0;
    logic       resetGame;
    logic       action_valid;
    logic [2:0] action1, action2;
    logic [2:0] pos1, pos2;
    logic [2:0] health1, health2;
    logic       first_win, second_win, draw, busy1, busy2, round_over;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fight_arena dut (
        .clk(clk), .resetGame(resetGame), .action_valid(action_valid),
        .action1(action1), .action2(action2),
        .pos1(pos1), .pos2(pos2), .health1(health1), .health2(health2),
        .first_win(first_win), .second_win(second_win), .draw(draw),
        .busy1(busy1), .busy2(busy2), .round_over(round_over)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] a1, input logic [2:0] a2, input logic v);
        @(negedge clk);
        action1 = a1; action2 = a2; action_valid = v;
        @(posedge clk);
        #1;
    endtask

    // a strike followed by enough idle cycles for cooldown to expire
    task automatic strike(input logic [2:0] a1, input logic [2:0] a2);
        step(a1, a2, 1'b1);
        step(I, I, 1'b1);
        step(I, I, 1'b1);
    endtask

    task automatic chk_pos(input string tag, input int p1, input int p2);
        chk({tag, ".pos1"}, 32'(pos1), p1);
        chk({tag, ".pos2"}, 32'(pos2), p2);
    endtask

    task automatic chk_hp(input string tag, input int h1, input int h2);
        chk({tag, ".health1"}, 32'(health1), h1);
        chk({tag, ".health2"}, 32'(health2), h2);
    endtask

    task automatic chk_flags(input string tag, input logic fw, input logic sw, input logic dr, input logic ov);
        chk({tag, ".first_win"},  32'(first_win),  32'(fw));
        chk({tag, ".second_win"}, 32'(second_win), 32'(sw));
        chk({tag, ".draw"},       32'(draw),       32'(dr));
        chk({tag, ".round_over"}, 32'(round_over), 32'(ov));
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetGame = 1'b0;
        action_valid = 1'b0; action1 = I; action2 = I;
        @(negedge clk);
        resetGame = 1'b1;
    endtask

    initial begin
        resetGame = 1'b0;
        action_valid = 1'b0; action1 = I; action2 = I;
        repeat (2) @(negedge clk);
        resetGame = 1'b1;
        #1;
        chk_pos("rst", 0, 7);
        chk_hp("rst", 7, 7);
        chk_flags("rst", 0, 0, 0, 0);
        chk("rst.busy1", 32'(busy1), 0);
        chk("rst.busy2", 32'(busy2), 0);

        // clamps at both track ends
        step(L, R, 1'b1);      chk_pos("clamp", 0, 7);

        // approach: 1/6, 2/5, 3/4, then blocked at gap 1
        step(R, L, 1'b1);      chk_pos("walk1", 1, 6);
        step(R, L, 1'b1);      chk_pos("walk2", 2, 5);
        step(R, L, 1'b1);      chk_pos("walk3", 3, 4);
        step(R, L, 1'b1);      chk_pos("blk_gap1", 3, 4);

        // attack, then repeat while busy is ignored
        step(A, I, 1'b1);      chk_hp("atk1", 7, 6); chk("atk1.busy1", 32'(busy1), 1);
        step(A, I, 1'b1);      chk_hp("atk_busy", 7, 6); chk("atk_busy.busy1", 32'(busy1), 1);
        step(I, I, 1'b1);      chk("cool_done.busy1", 32'(busy1), 0);

        // heavy into defend deals 1
        step(H, D, 1'b1);      chk_hp("heavy_def", 7, 5);
        // cooldown runs with action_valid low; moves ignored
        step(R, R, 1'b0);      chk_pos("novalid", 3, 4); chk("novalid.busy1", 32'(busy1), 1);
        step(R, R, 1'b0);      chk("novalid2.busy1", 32'(busy1), 0);
        step(H, I, 1'b1);      chk_hp("heavy", 7, 3);
        // defended plain attack deals 0
        step(D, A, 1'b1);      chk_hp("atk_def", 7, 3); chk("atk_def.busy2", 32'(busy2), 1);

        // gap 2, converge blocked, miss at gap 2, away+toward both apply
        step(I, R, 1'b1);      chk_pos("p2_right", 3, 5);
        step(R, L, 1'b1);      chk_pos("converge", 3, 5);
        step(A, I, 1'b1);      chk_hp("miss", 7, 3); chk("miss.busy1", 32'(busy1), 1);
        step(R, R, 1'b1);      chk_pos("away_toward", 4, 6);

        // async reset mid-cooldown
        step(I, A, 1'b1);      chk("pre_rst.busy2", 32'(busy2), 1);
        @(negedge clk);
        resetGame = 1'b0;
        #2;
        chk_pos("async_rst", 0, 7);
        chk_hp("async_rst", 7, 7);
        chk("async_rst.busy1", 32'(busy1), 0);
        chk("async_rst.busy2", 32'(busy2), 0);
        chk_flags("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        resetGame = 1'b1;
        step(R, I, 1'b1);      chk_pos("post_rst", 1, 7);

        // draw: trade heavies down to 1/1, then simultaneous attacks
        step(R, L, 1'b1);
        step(R, L, 1'b1);
        step(R, I, 1'b1);      chk_pos("draw_setup", 4, 5);
        strike(H, H);
        strike(H, H);
        strike(H, H);          chk_hp("draw_hp1", 1, 1);
        chk("draw_pre.round_over", 32'(round_over), 0);
        step(A, A, 1'b1);      chk_hp("draw", 0, 0); chk_flags("draw", 0, 0, 1, 1);
        step(L, R, 1'b1);      chk_pos("over_hold", 4, 5); chk_flags("over_hold", 0, 0, 1, 1);

        // player 1 wins; last heavy on health 1 saturates at 0
        do_reset();
        step(R, L, 1'b1);
        step(R, L, 1'b1);
        step(R, L, 1'b1);      chk_pos("win_setup", 3, 4);
        strike(H, I);
        strike(H, I);
        strike(H, I);          chk_hp("win_hp", 7, 1); chk_flags("win_pre", 0, 0, 0, 0);
        step(H, I, 1'b1);      chk_hp("win_sat", 7, 0); chk_flags("win", 1, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
